// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: decode backpressure, branch redirect,
// instruction memory port and the fetch result presented to decode.
interface pc_fetch_if #(
  parameter int PC_W = 16
);
  logic            stall;
  logic            pc_branch_sel;
  logic [PC_W-1:0] branch_target;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     fetch_instr;
  logic [PC_W-1:0] fetch_pc;
  logic            fetch_valid;
  logic            flush;
  logic            halted;

  modport master (
    output stall,
    output pc_branch_sel,
    output branch_target,
    output imem_rdata,
    input  imem_addr,
    input  fetch_instr,
    input  fetch_pc,
    input  fetch_valid,
    input  flush,
    input  halted
  );

  modport slave (
    input  stall,
    input  pc_branch_sel,
    input  branch_target,
    input  imem_rdata,
    output imem_addr,
    output fetch_instr,
    output fetch_pc,
    output fetch_valid,
    output flush,
    output halted
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage: branch redirect with a squash
// window, stall hold over a synchronous imem, and halt detection.
module pc_fetch_unit #(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              FLUSH_DEPTH = 2,
  parameter logic [4:0]      HALT_OP     = 5'b11111
) (
  input  logic     clk,
  input  logic     rst,
  pc_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    HALT
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_DEPTH - 1);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] fetch_pc_q;
  logic            fetch_valid_q;
  logic            flush_q;
  logic            halted_q;
  logic [2:0]      flush_cnt;
  logic            held;
  logic [31:0]     instr_q;
  logic [31:0]     instr;
  logic            take_br;
  logic            halt_hit;

  // imem keeps reading at pc while stalled, so the
  // presented instruction is parked in instr_q
  assign instr = held ? instr_q : bus.imem_rdata;

  assign take_br = bus.pc_branch_sel
                && (state != HALT);

  assign halt_hit = (state == RUN)
                 && fetch_valid_q
                 && !bus.stall
                 && !bus.pc_branch_sel
                 && (instr[31:27] == HALT_OP);

  assign bus.imem_addr   = pc;
  assign bus.fetch_instr = instr;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;
  assign bus.halted      = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      pc            <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      flush_cnt     <= 3'd0;
      held          <= 1'b0;
      instr_q       <= 32'd0;
    end else begin
      flush_q <= 1'b0;
      priority case (1'b1)
        take_br: begin
          pc            <= bus.branch_target;
          flush_q       <= 1'b1;
          fetch_valid_q <= 1'b0;
          flush_cnt     <= CNT_INIT;
          held          <= 1'b0;
          state         <= FLUSH;
        end
        halt_hit: begin
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b1;
          held          <= 1'b0;
          state         <= HALT;
        end
        (state == HALT): begin
        end
        bus.stall: begin
          held    <= 1'b1;
          instr_q <= instr;
        end
        // pc parks on the target until the last squashed
        // slot so the first valid fetch is the target
        (state == FLUSH): begin
          held       <= 1'b0;
          fetch_pc_q <= pc;
          if (flush_cnt == 3'd0) begin
            pc            <= pc + 1'b1;
            fetch_valid_q <= 1'b1;
            state         <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          held          <= 1'b0;
          pc            <= pc + 1'b1;
          fetch_pc_q    <= pc;
          fetch_valid_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Random + directed bench for pc_fetch_unit: an in-order fetch
// stream model feeds a scoreboard queue checked by a monitor.
module tb_pc_fetch_unit;

  localparam int          PC_W        = 16;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam int          FLUSH_DEPTH = 2;
  localparam logic [4:0]  HALT_OP     = 5'b11111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_fetch_if #(.PC_W(PC_W)) bus();

  pc_fetch_unit #(
    .PC_W       (PC_W),
    .RESET_PC   (RESET_PC),
    .FLUSH_DEPTH(FLUSH_DEPTH),
    .HALT_OP    (HALT_OP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];

  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  // reference model: program-order pcs expected at decode
  logic [15:0] exp_q [$];
  bit          exp_halted;
  bit          br_prev;
  int          since_br;
  bit          br_stalled;
  bit          mon_en;
  int          n_checks;
  int          n_err;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == HALT_OP) w[31] = 1'b0;
    return w;
  endfunction

  task automatic model_restart(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(start + 16'(i));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"},  bus.fetch_valid, 0);
    chk({tag, "_flush"},  bus.flush, 0);
    chk({tag, "_halted"}, bus.halted, 0);
    chk({tag, "_pc"},     bus.fetch_pc, RESET_PC);
    chk({tag, "_addr"},   bus.imem_addr, RESET_PC);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    bus.stall = 1'b0;
    bus.pc_branch_sel = 1'b0;
    @(posedge clk); #1;
    check_reset("rst");
    model_restart(RESET_PC);
    exp_halted = 1'b0;
    br_prev = 1'b0;
    since_br = 99;
    br_stalled = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drive(input bit st,
                       input bit br,
                       input logic [15:0] tgt);
    @(posedge clk); #1;
    bus.stall = st;
    bus.pc_branch_sel = br;
    bus.branch_target = br ? tgt : 16'($urandom);
    if (br && !exp_halted) model_restart(tgt);
  endtask

  always @(negedge clk) begin : monitor
    int          s;
    logic        br_now;
    logic        consume;
    logic [15:0] epc;
    if (mon_en && !rst) begin
      chk("halted", bus.halted, exp_halted);
      chk("flush", bus.flush, br_prev);
      if (exp_halted) chk("valid_in_halt", bus.fetch_valid, 0);
      s = (since_br >= 99) ? 99 : since_br + 1;
      if (s <= FLUSH_DEPTH)
        chk("flush_bubble", bus.fetch_valid, 0);
      else if (s == FLUSH_DEPTH + 1 && !br_stalled)
        chk("flush_exit_valid", bus.fetch_valid, 1);
      br_now  = bus.pc_branch_sel && !exp_halted;
      consume = bus.fetch_valid && !bus.stall
             && !bus.pc_branch_sel;
      if (consume) begin
        if (exp_q.size() == 0) begin
          chk("queue_empty", 1, 0);
        end else begin
          epc = exp_q.pop_front();
          if (exp_q.size() < 4)
            exp_q.push_back((exp_q.size() == 0 ? epc : exp_q[$]) + 16'd1);
          chk("fetch_pc", bus.fetch_pc, epc);
          chk("fetch_instr", bus.fetch_instr, mem[epc]);
          if (mem[epc][31:27] == HALT_OP) exp_halted = 1'b1;
        end
      end
      br_prev = br_now;
      if (br_now) begin
        since_br = 0;
        br_stalled = 1'b0;
      end else begin
        since_br = s;
        br_stalled = br_stalled | bus.stall;
      end
    end
  end

  initial begin
    int          cyc;
    int          halt_wait;
    logic [15:0] tgt;
    n_checks = 0;
    n_err = 0;
    mon_en = 1'b0;
    bus.stall = 1'b0;
    bus.pc_branch_sel = 1'b0;
    bus.branch_target = '0;
    for (int i = 0; i < 65536; i++) mem[i] = rand_instr();
    mem[16'h0008] = {HALT_OP, 27'h0};
    do_reset();

    // halt at 'h08 with random stalls, then ignored branches
    cyc = 0;
    while (!exp_halted && cyc < 300) begin
      drive($urandom_range(0, 3) == 0, 1'b0, 16'h0);
      cyc++;
    end
    chk("halt_timeout", (cyc < 300), 1);
    repeat (3) drive(1'b0, 1'b0, 16'h0);
    repeat (10) drive($urandom_range(0, 1), 1'b1, 16'($urandom));
    do_reset();
    mem[16'h0008] = rand_instr();

    // redirect, stall hold and address wrap
    repeat (6) drive(1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 16'h0040);
    repeat (5) drive(1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 16'h000f);
    repeat (3) drive(1'b0, 1'b0, 16'h0);
    repeat (3) drive(1'b1, 1'b0, 16'h0);
    repeat (3) drive(1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 16'hfffe);
    repeat (8) drive(1'b0, 1'b0, 16'h0);

    // back-to-back branches over a wrong-path halt
    mem[16'h0021] = {HALT_OP, 27'h0};
    drive(1'b0, 1'b1, 16'h0020);
    drive(1'b0, 1'b1, 16'h0030);
    repeat (6) drive(1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 16'h0020);
    drive(1'b1, 1'b1, 16'h0030);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    check_reset("async");
    mem[16'h0021] = rand_instr();

    // random traffic with sparse halts
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 47) == 0)
             ? {HALT_OP, 27'($urandom)} : rand_instr();
    do_reset();
    halt_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_halted && halt_wait > 8) begin
        do_reset();
        halt_wait = 0;
      end else begin
        if (exp_halted) halt_wait++;
        case ($urandom_range(0, 3))
          0:       tgt = 16'hfffe;
          1:       tgt = 16'h0040;
          default: tgt = 16'($urandom);
        endcase
        drive($urandom_range(0, 3) == 0,
              $urandom_range(0, 99) < 8, tgt);
      end
    end
    drive(1'b0, 1'b0, 16'h0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
